// File: rtl/key_debounce_multi.sv
// key_debounce_multi: per-channel sync, debounce, press/release pulses and one-shot long-press pulse
module key_debounce_multi #(
    parameter int N_CH         = 4,
    parameter int DEBOUNCE_CYC = 200000,
    parameter int LONG_CYC     = 2000000,
    parameter bit ACTIVE_HIGH  = 1'b1
) (
    input  logic            clk_cis,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] sw_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYC);
    localparam int HW = $clog2(LONG_CYC + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYC - 1);
    logic [N_CH-1:0] s1, s2;
    always_ff @(posedge clk_cis) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_in ^ {N_CH{~ACTIVE_HIGH}};
            s2 <= s1;
        end
    end
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [DW-1:0] dcnt;
        logic [HW-1:0] hcnt;
        logic lvl, prs, rel, lng, fired;
        always_ff @(posedge clk_cis) begin
            if (!rst_n) begin
                dcnt <= '0;
                lvl  <= 1'b0;
                prs  <= 1'b0;
                rel  <= 1'b0;
            end else begin
                prs <= 1'b0;
                rel <= 1'b0;
                if (s2[c] == lvl) begin
                    dcnt <= '0;
                end else if (dcnt == D_LAST) begin
                    dcnt <= '0;
                    lvl  <= s2[c];
                    prs  <= s2[c];
                    rel  <= ~s2[c];
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end
        // hcnt parks at H_LAST once fired so it cannot wrap during long holds
        always_ff @(posedge clk_cis) begin
            if (!rst_n || !lvl) begin
                hcnt  <= '0;
                fired <= 1'b0;
                lng   <= 1'b0;
            end else if (!fired && hcnt == H_LAST) begin
                fired <= 1'b1;
                lng   <= 1'b1;
            end else begin
                lng  <= 1'b0;
                hcnt <= fired ? hcnt : hcnt + 1'b1;
            end
        end
        assign sw_level[c]      = lvl;
        assign press_pulse[c]   = prs;
        assign release_pulse[c] = rel;
        assign long_pulse[c]    = lng;
    end
endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: directed checks of debounce, pulses, long press, reset and active-low polarity
module tb_key_debounce_multi;
    logic clk_cis = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] sw_hi = 2'b00, sw_lo = 2'b11;
    logic [1:0] lvl_hi, prs_hi, rel_hi, lng_hi;
    logic [1:0] lvl_lo, prs_lo, rel_lo, lng_lo;
    int n_chk = 0, n_fail = 0;
    always #5 clk_cis = ~clk_cis;
    key_debounce_multi #(.N_CH(2), .DEBOUNCE_CYC(8), .LONG_CYC(20), .ACTIVE_HIGH(1'b1)) u_hi (
        .clk_cis(clk_cis), .rst_n(rst_n), .sw_in(sw_hi),
        .sw_level(lvl_hi), .press_pulse(prs_hi), .release_pulse(rel_hi), .long_pulse(lng_hi)
    );
    key_debounce_multi #(.N_CH(2), .DEBOUNCE_CYC(8), .LONG_CYC(20), .ACTIVE_HIGH(1'b0)) u_lo (
        .clk_cis(clk_cis), .rst_n(rst_n), .sw_in(sw_lo),
        .sw_level(lvl_lo), .press_pulse(prs_lo), .release_pulse(rel_lo), .long_pulse(lng_lo)
    );
    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask
    task automatic chk4(input bit lo, input string nm, input int e,
                        input logic [1:0] l, input logic [1:0] p, input logic [1:0] r, input logic [1:0] g);
        check($sformatf("%s e=%0d level", nm, e), lo ? lvl_lo : lvl_hi, l);
        check($sformatf("%s e=%0d press", nm, e), lo ? prs_lo : prs_hi, p);
        check($sformatf("%s e=%0d release", nm, e), lo ? rel_lo : rel_hi, r);
        check($sformatf("%s e=%0d long", nm, e), lo ? lng_lo : lng_hi, g);
    endtask
    task automatic tick();
        @(posedge clk_cis);
        #1;
    endtask
    task automatic do_reset();
        sw_hi = 2'b00;
        sw_lo = 2'b11;
        rst_n = 1'b0;
        tick();
        chk4(1'b0, "reset_hi", 0, 2'b00, 2'b00, 2'b00, 2'b00);
        chk4(1'b1, "reset_lo", 0, 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
    endtask
    initial begin
        #2;
        do_reset();
        // clean press, long press, release, re-press with second long pulse
        for (int e = 0; e <= 130; e++) begin
            sw_hi = {1'b0, (e < 60) || (e >= 76 && e < 116)};
            tick();
            chk4(1'b0, "long", e, {1'b0, (e >= 9 && e < 69) || (e >= 85 && e < 125)},
                 {1'b0, e == 9 || e == 85}, {1'b0, e == 69 || e == 125}, {1'b0, e == 29 || e == 105});
        end
        do_reset();
        // 7-sample burst rejected, then a press restarted by a 1-cycle glitch
        for (int e = 0; e <= 40; e++) begin
            sw_hi = {(e < 7) || (e >= 20 && e != 24), 1'b0};
            tick();
            chk4(1'b0, "glitch", e, {e >= 34, 1'b0}, {e == 34, 1'b0}, 2'b00, 2'b00);
        end
        do_reset();
        for (int e = 0; e <= 40; e++) begin
            sw_hi = {1'b0, e < 15};
            tick();
            chk4(1'b0, "short", e, {1'b0, e >= 9 && e < 24}, {1'b0, e == 9}, {1'b0, e == 24}, 2'b00);
        end
        do_reset();
        // reset at edge 5 (before press) and at edge 20 (while level is high)
        for (int e = 0; e <= 35; e++) begin
            sw_hi = 2'b01;
            rst_n = !(e == 5 || e == 20);
            tick();
            chk4(1'b0, "rstmid", e, {1'b0, (e >= 15 && e < 20) || e >= 30},
                 {1'b0, e == 15 || e == 30}, 2'b00, 2'b00);
        end
        rst_n = 1'b1;
        do_reset();
        // active-low: ch0 level drops on the edge hcnt reaches 19, so only ch1 gets a long pulse
        for (int e = 0; e <= 50; e++) begin
            sw_lo = {~(e < 35), ~(e < 19)};
            tick();
            chk4(1'b1, "actlow", e, {e >= 9 && e < 44, e >= 9 && e < 28},
                 {e == 9, e == 9}, {e == 44, e == 28}, {e == 29, 1'b0});
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
